mips_regfile_sb: RTL and testbench

Parametrised register file with an integrated busy-bit scoreboard for the pipelined MIPS core. It replaces the fixed two-read/one-write `regfile` with configurable width, depth and read-port count. It adds same-cycle write-back bypass and per-register pending-write tracking, so the control unit can detect RAW/WAW hazards and stall. It sits between ID (read/issue) and WB (write).

---
 rtl/mips_regfile_sb_pkg.sv | 6 +
 rtl/mips_regfile_sb_reg_scoreboard.sv | 45 ++++
 rtl/mips_regfile_sb.sv | 64 ++++++
 tb/tb_mips_regfile_sb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_regfile_sb_pkg.sv
// mips_regfile_sb_pkg: shared constants for the register file and its scoreboard.
package mips_regfile_sb_pkg;
    localparam int          REG_ZERO        = 0;
    localparam logic [6:0]  DEBUG_BUSY_ADDR = 7'h7F;
    localparam logic [31:0] DEBUG_INVALID   = 32'hFFFF_FFFF;
endpackage

// File: rtl/mips_regfile_sb_reg_scoreboard.sv
// reg_scoreboard: per-register busy bits, WAW issue check and busy population counter.
module reg_scoreboard
    import mips_regfile_sb_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_dst,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic                   flush,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic                   issue_ok,
    output logic [ADDR_W:0]        busy_cnt
);
    localparam int NREG = 1 << ADDR_W;
    localparam int CW   = ADDR_W + 1;
    logic            set;
    logic            clr;
    logic [NREG-1:0] nxt;
    assign issue_ok = !(|issue_dst) || !busy[issue_dst] || (wb_en && wb_addr == issue_dst);
    assign set      = issue_en && issue_ok && |issue_dst && !flush;
    // A write-back to a register being re-claimed this cycle must not clear it.
    assign clr      = wb_en && |wb_addr && busy[wb_addr] && !(set && issue_dst == wb_addr);
    always_comb begin
        nxt = busy;
        if (clr) nxt[wb_addr] = 1'b0;
        if (set) nxt[issue_dst] = 1'b1;
        nxt[REG_ZERO] = 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else if (flush) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= nxt;
            busy_cnt <= busy_cnt + CW'(set && !busy[issue_dst]) - CW'(clr);
        end
    end
endmodule

// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb: parametrised register file with WB bypass and busy-bit scoreboard.
// REGFILE_DEBUG_EN adds a registered debug read port (debug_addr/debug_data).
module mips_regfile_sb
    import mips_regfile_sb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [RD_PORTS*DATA_W-1:0] rd_data,
    output logic [RD_PORTS-1:0]        rd_busy,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_dst,
    output logic                       issue_ok,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       flush,
    output logic [ADDR_W:0]            busy_cnt
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [6:0]                 debug_addr,
    output logic [31:0]                debug_data
`endif
);
    localparam int NREG = 1 << ADDR_W;
    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk(clk),
        .rst(rst),
        .issue_en(issue_en),
        .issue_dst(issue_dst),
        .wb_en(wb_en),
        .wb_addr(wb_addr),
        .flush(flush),
        .busy(busy),
        .issue_ok(issue_ok),
        .busy_cnt(busy_cnt)
    );
    // r0 is never written, so its reset value keeps it reading zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int i = 0; i < NREG; i++) regs[i] <= '0;
        else if (wb_en && |wb_addr) regs[wb_addr] <= wb_data;
    end
    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              byp;
        assign a                          = rd_addr[i*ADDR_W +: ADDR_W];
        assign byp                        = wb_en && wb_addr == a && |a;
        assign rd_data[i*DATA_W +: DATA_W] = byp ? wb_data : regs[a];
        assign rd_busy[i]                 = !byp && busy[a];
    end
`ifdef REGFILE_DEBUG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) debug_data <= '0;
        else debug_data <= 32'(debug_addr) < 32'(NREG) ? 32'(regs[ADDR_W'(debug_addr)]) :
                           debug_addr == DEBUG_BUSY_ADDR ? 32'(busy) : DEBUG_INVALID;
    end
`endif
endmodule

// File: tb/tb_mips_regfile_sb.sv
// tb_mips_regfile_sb: directed vector table, reset/debug sequences and random run vs a reference model.
module tb_mips_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RP = 2;
    localparam int NR = 32;
    logic clk = 1'b0;
    logic rst;
    logic [RP*AW-1:0] rd_addr;
    logic [RP*DW-1:0] rd_data;
    logic [RP-1:0]    rd_busy;
    logic             issue_en;
    logic [AW-1:0]    issue_dst;
    logic             issue_ok;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;
    logic             flush;
    logic [AW:0]      busy_cnt;
`ifdef REGFILE_DEBUG_EN
    logic [6:0]       debug_addr;
    logic [31:0]      debug_data;
`endif
    int errors = 0;
    int checks = 0;
    logic [DW-1:0] mem [NR];
    bit            mbusy [NR];

    typedef struct {
        logic [AW-1:0] a0, a1;
        logic          ie;
        logic [AW-1:0] id;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          fl;
        logic [DW-1:0] d0, d1;
        logic          b0, b1, ok;
        logic [AW:0]   cnt;
    } vec_t;
    vec_t tbl [18];

    mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP)) dut (
        .clk(clk),
        .rst(rst),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_busy(rd_busy),
        .issue_en(issue_en),
        .issue_dst(issue_dst),
        .issue_ok(issue_ok),
        .wb_en(wb_en),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .flush(flush),
        .busy_cnt(busy_cnt)
`ifdef REGFILE_DEBUG_EN
        ,
        .debug_addr(debug_addr),
        .debug_data(debug_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic ie,
                         input logic [AW-1:0] id, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic fl);
        rd_addr   = {a1, a0};
        issue_en  = ie;
        issue_dst = id;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        flush     = fl;
    endtask

    task automatic m_reset();
        for (int r = 0; r < NR; r++) begin
            mem[r]   = '0;
            mbusy[r] = 1'b0;
        end
    endtask

    function automatic bit m_byp(input logic [AW-1:0] a);
        return wb_en && wb_addr == a && a != 0;
    endfunction

    function automatic bit m_ok();
        return issue_dst == 0 || !mbusy[issue_dst] || (wb_en && wb_addr == issue_dst);
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int r = 0; r < NR; r++) n += int'(mbusy[r]);
        return n;
    endfunction

    // Model of one clock edge: write data, then flush / clear / claim in priority order.
    task automatic m_update();
        bit ok;
        ok = m_ok();
        if (wb_en && wb_addr != 0) mem[wb_addr] = wb_data;
        if (flush) begin
            for (int r = 0; r < NR; r++) mbusy[r] = 1'b0;
        end else begin
            if (wb_en && wb_addr != 0) mbusy[wb_addr] = 1'b0;
            if (issue_en && ok && issue_dst != 0) mbusy[issue_dst] = 1'b1;
        end
    endtask

    task automatic check_model(input string t);
        logic [AW-1:0] a;
        for (int p = 0; p < RP; p++) begin
            a = rd_addr[p*AW +: AW];
            chk($sformatf("%s.data%0d", t, p), rd_data[p*DW +: DW], m_byp(a) ? wb_data : mem[a]);
            chk($sformatf("%s.busy%0d", t, p), 32'(rd_busy[p]), 32'(!m_byp(a) && mbusy[a]));
        end
        chk({t, ".ok"}, 32'(issue_ok), 32'(m_ok()));
        chk({t, ".cnt"}, 32'(busy_cnt), m_cnt());
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    initial begin
        //        a0 a1 ie id we wa wd            fl  d0            d1            b0 b1 ok cnt
        tbl[0]  = '{1, 2, 0, 0, 0, 0, 0,            0,  0,            0,            0, 0, 1, 0};
        tbl[1]  = '{5, 0, 1, 5, 0, 0, 0,            0,  0,            0,            0, 0, 1, 0};
        tbl[2]  = '{5, 0, 1, 5, 0, 0, 0,            0,  0,            0,            1, 0, 0, 1};
        tbl[3]  = '{5, 5, 0, 0, 0, 0, 0,            0,  0,            0,            1, 1, 1, 1};
        tbl[4]  = '{5, 1, 0, 0, 1, 5, 32'hDEADBEEF, 0,  32'hDEADBEEF, 0,            0, 0, 1, 1};
        tbl[5]  = '{5, 1, 0, 0, 0, 0, 0,            0,  32'hDEADBEEF, 0,            0, 0, 1, 0};
        tbl[6]  = '{7, 5, 1, 7, 0, 0, 0,            0,  0,            32'hDEADBEEF, 0, 0, 1, 0};
        tbl[7]  = '{7, 7, 1, 7, 1, 7, 32'h11,       0,  32'h11,       32'h11,       0, 0, 1, 1};
        tbl[8]  = '{7, 5, 0, 0, 0, 0, 0,            0,  32'h11,       32'hDEADBEEF, 1, 0, 1, 1};
        tbl[9]  = '{3, 4, 1, 3, 0, 0, 0,            0,  0,            0,            0, 0, 1, 1};
        tbl[10] = '{3, 4, 1, 4, 0, 0, 0,            0,  0,            0,            1, 0, 1, 2};
        tbl[11] = '{3, 6, 1, 6, 0, 0, 0,            0,  0,            0,            1, 0, 1, 3};
        tbl[12] = '{3, 6, 1, 8, 0, 0, 0,            1,  0,            0,            1, 1, 1, 4};
        tbl[13] = '{8, 3, 0, 0, 0, 0, 0,            0,  0,            0,            0, 0, 1, 0};
        tbl[14] = '{0, 0, 1, 0, 1, 0, 32'h1234,     0,  0,            0,            0, 0, 1, 0};
        tbl[15] = '{0, 7, 0, 0, 0, 0, 0,            0,  0,            32'h11,       0, 0, 1, 0};
        tbl[16] = '{9, 0, 0, 0, 1, 9, 32'hCAFE,     0,  32'hCAFE,     0,            0, 0, 1, 0};
        tbl[17] = '{9, 7, 0, 0, 0, 0, 0,            0,  32'hCAFE,     32'h11,       0, 0, 1, 0};

        rst = 1'b1;
        drive(1, 2, 0, 0, 0, 0, 0, 0);
`ifdef REGFILE_DEBUG_EN
        debug_addr = 7'd0;
`endif
        m_reset();
        #12;
        chk("rst.data", rd_data[31:0], 0);
        chk("rst.busy", 32'(rd_busy), 0);
        chk("rst.cnt", 32'(busy_cnt), 0);
        chk("rst.ok", 32'(issue_ok), 1);
`ifdef REGFILE_DEBUG_EN
        chk("rst.debug", debug_data, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 18; k++) begin
            drive(tbl[k].a0, tbl[k].a1, tbl[k].ie, tbl[k].id, tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].fl);
            @(negedge clk);
            chk($sformatf("t%0d.d0", k), rd_data[31:0], tbl[k].d0);
            chk($sformatf("t%0d.d1", k), rd_data[63:32], tbl[k].d1);
            chk($sformatf("t%0d.b0", k), 32'(rd_busy[0]), 32'(tbl[k].b0));
            chk($sformatf("t%0d.b1", k), 32'(rd_busy[1]), 32'(tbl[k].b1));
            chk($sformatf("t%0d.ok", k), 32'(issue_ok), 32'(tbl[k].ok));
            chk($sformatf("t%0d.cnt", k), 32'(busy_cnt), 32'(tbl[k].cnt));
            tick();
        end

`ifdef REGFILE_DEBUG_EN
        drive(0, 0, 1, 12, 0, 0, 0, 0);
        debug_addr = 7'd9;
        tick();
        chk("dbg.reg9", debug_data, 32'hCAFE);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        debug_addr = 7'h40;
        tick();
        chk("dbg.invalid", debug_data, 32'hFFFF_FFFF);
        debug_addr = 7'h7F;
        tick();
        chk("dbg.busyvec", debug_data, 32'h1 << 12);
        debug_addr = 7'd0;
`endif

        // Asynchronous reset in the middle of a cycle clears data and claims at once.
        drive(0, 0, 1, 10, 1, 11, 32'h55, 0);
        tick();
        drive(11, 10, 0, 10, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre.d0", rd_data[31:0], 32'h55);
        chk("pre.b1", 32'(rd_busy[1]), 1);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk("arst.d0", rd_data[31:0], 0);
        chk("arst.busy", 32'(rd_busy), 0);
        chk("arst.cnt", 32'(busy_cnt), 0);
        chk("arst.ok", 32'(issue_ok), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 600; n++) begin
            drive(AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 9)),
                  DW'($urandom), $urandom_range(0, 15) == 0);
            @(negedge clk);
            check_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
